deriv_lut_loader: RTL and testbench

//  Writable surrogate-derivative lookup table for the FF-STDP learning path: the write-side counterpart of the

---
 rtl/snn_ff_lut_pkg.sv | 13 +
 rtl/deriv_lut_loader_if.sv | 15 +
 rtl/deriv_lut_mem.sv | 43 ++++
 rtl/deriv_lut_loader.sv | 108 ++++++++++
 tb/tb_deriv_lut_loader.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/snn_ff_lut_pkg.sv
// Shared types and default sizes for the FF-STDP lookup-table blocks.
package snn_ff_lut_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } lut_state_e;

endpackage

// File: rtl/deriv_lut_loader_if.sv
// Valid/ready write stream that carries derivative table entries from host/DMA into the loader.
interface deriv_lut_loader_if
    import snn_ff_lut_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/deriv_lut_mem.sv
// Derivative table storage: one write port, registered read-first read port, cleared by reset.
module deriv_lut_mem
    import snn_ff_lut_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the table must read all-zero straight out of reset, so the array is reset like
    // ordinary flops; this deliberately rules out mapping it onto a block RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // NOTE: non-blocking updates on both arrays are what give read-first behaviour: a read of
    // the address being written on the same edge sees the entry's previous contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/deriv_lut_loader.sv
// Writable surrogate-derivative table: streams entries into an address window, serves ROM-style reads.
module deriv_lut_loader
    import snn_ff_lut_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  load_abort,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_len,
    deriv_lut_loader_if.slave     stream,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  table_valid,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    lut_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH:0]   rem_q;
    logic                  start_ok;
    logic                  beat;

    // Abort dominates both a new start and a beat arriving in the same cycle.
    assign start_ok = (state_q == IDLE) && load_start && !load_abort;
    assign beat     = stream.s_ready && stream.s_valid && !load_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_ok) state_d = (load_len == '0) ? DONE : LOAD;
            LOAD: begin
                if (load_abort) begin
                    state_d = IDLE;
                end else if (beat && (rem_q == REM_ONE)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stream.s_ready = 1'b0;
        load_busy      = 1'b0;
        load_done      = 1'b0;
        unique case (state_q)
            LOAD: begin
                stream.s_ready = 1'b1;
                load_busy      = 1'b1;
            end
            DONE:    load_done = !load_abort;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rem_q       <= '0;
            table_valid <= 1'b0;
        end else begin
            if (start_ok) begin
                ptr_q       <= load_base;
                rem_q       <= (load_len > DEPTH) ? DEPTH : load_len;
                table_valid <= 1'b0;
            end else if (beat) begin
                ptr_q <= ptr_q + 1'b1;
                rem_q <= rem_q - 1'b1;
            end
            if ((state_q == DONE) && !load_abort) begin
                table_valid <= 1'b1;
            end
        end
    end

    deriv_lut_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (beat),
        .waddr (ptr_q),
        .wdata (stream.s_data),
        .raddr (addr),
        .rdata (dout)
    );

endmodule

// File: tb/tb_deriv_lut_loader.sv
// Directed bench for deriv_lut_loader: reset clear, full load, wrap, abort, collision and corner lengths.
module tb_deriv_lut_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_start;
    logic       load_abort;
    logic [7:0] load_base;
    logic [8:0] load_len;
    logic       load_busy;
    logic       load_done;
    logic       table_valid;
    logic [7:0] addr;
    logic [7:0] dout;

    int n_checks = 0;
    int n_errors = 0;

    deriv_lut_loader_if #(.DATA_WIDTH(8)) stream ();

    deriv_lut_loader #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_abort  (load_abort),
        .load_base   (load_base),
        .load_len    (load_len),
        .stream      (stream),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .table_valid (table_valid),
        .addr        (addr),
        .dout        (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        addr = a;
        tick();
        check(tag, dout, exp);
    endtask

    // Runs one load; lat = edges from the start-sampling edge to the first load_done, -1 if none.
    task automatic run_load(input logic [7:0] base, input logic [8:0] len, input logic [7:0] seed,
                            input bit gaps, input int abort_at,
                            output int lat, output bit ready_seen);
        int         n_eff;
        int         beats;
        logic [7:0] p;
        lat        = -1;
        ready_seen = 1'b0;
        beats      = 0;
        p          = base;
        n_eff      = (len > 9'd256) ? 256 : int'(len);
        load_base  = base;
        load_len   = len;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int cyc = 1; cyc < 1200; cyc++) begin
            ready_seen = ready_seen | stream.s_ready;
            if (load_done) begin
                lat = cyc;
                break;
            end
            if (!load_busy) break;
            stream.s_data  = p ^ seed;
            stream.s_valid = (beats < n_eff) &&
                             (!gaps || beats == abort_at || $urandom_range(0, 2) != 0);
            load_abort     = stream.s_valid && (beats == abort_at);
            tick();
            if (stream.s_valid && !load_abort) begin
                p = p + 8'd1;
                beats++;
            end
            load_abort = 1'b0;
        end
        stream.s_valid = 1'b0;
        tick();
    endtask

    initial begin
        int lat;
        bit rs;
        rst_n          = 1'b0;
        load_start     = 1'b0;
        load_abort     = 1'b0;
        load_base      = '0;
        load_len       = '0;
        stream.s_valid = 1'b0;
        stream.s_data  = '0;
        addr           = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", stream.s_ready, 0);
        check("rst_busy", load_busy, 0);
        check("rst_done", load_done, 0);
        check("rst_tvalid", table_valid, 0);
        check("rst_dout", dout, 0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a load after five accepted beats.
        load_base  = 8'd0;
        load_len   = 9'd20;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stream.s_valid = 1'b1;
            stream.s_data  = 8'(8'h11 + i);
            addr           = 8'(i);
            tick();
        end
        check("mid_busy_before", load_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", stream.s_ready, 0);
        check("mid_rst_busy", load_busy, 0);
        check("mid_rst_done", load_done, 0);
        check("mid_rst_tvalid", table_valid, 0);
        check("mid_rst_dout", dout, 0);
        stream.s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mid_idle_busy", load_busy, 0);
        for (int a = 0; a < 256; a++) read_chk("mid_clear", 8'(a), 8'h00);

        // Full table, no gaps.
        run_load(8'd0, 9'd256, 8'hA5, 1'b0, -1, lat, rs);
        check("full_lat", lat, 257);
        check("full_ready_seen", rs, 1);
        check("full_done_pulse", load_done, 0);
        check("full_tvalid", table_valid, 1);
        for (int a = 0; a < 256; a++) read_chk("full_data", 8'(a), 8'(a) ^ 8'hA5);

        // Window wrapping past the top of the table, with valid gaps.
        run_load(8'd250, 9'd10, 8'h3C, 1'b1, -1, lat, rs);
        check("wrap_done_seen", lat > 0, 1);
        check("wrap_tvalid", table_valid, 1);
        for (int a = 250; a < 256; a++) read_chk("wrap_hi", 8'(a), 8'(a) ^ 8'h3C);
        for (int a = 0; a < 4; a++) read_chk("wrap_lo", 8'(a), 8'(a) ^ 8'h3C);
        read_chk("wrap_keep4", 8'd4, 8'h04 ^ 8'hA5);
        read_chk("wrap_keep249", 8'd249, 8'd249 ^ 8'hA5);

        // Abort on the fourth beat of eight.
        run_load(8'd100, 9'd8, 8'h5A, 1'b0, 3, lat, rs);
        check("abort_no_done", lat, 32'hFFFF_FFFF);
        check("abort_tvalid", table_valid, 0);
        check("abort_busy", load_busy, 0);
        for (int a = 100; a < 103; a++) read_chk("abort_written", 8'(a), 8'(a) ^ 8'h5A);
        read_chk("abort_beat4", 8'd103, 8'd103 ^ 8'hA5);
        read_chk("abort_beat5", 8'd104, 8'd104 ^ 8'hA5);

        // Read-first collision at address 20.
        addr = 8'd20;
        run_load(8'd20, 9'd1, 8'hEA, 1'b0, -1, lat, rs);
        check("coll_prep_done", lat, 2);
        load_base  = 8'd20;
        load_len   = 9'd1;
        load_start = 1'b1;
        tick();
        load_start     = 1'b0;
        stream.s_valid = 1'b1;
        stream.s_data  = 8'h7F;
        tick();
        stream.s_valid = 1'b0;
        check("coll_old", dout, 8'hFE);
        check("coll_done", load_done, 1);
        tick();
        check("coll_new", dout, 8'h7F);
        check("coll_tvalid", table_valid, 1);

        // Abort and start together in IDLE: no load.
        load_base  = 8'd40;
        load_len   = 9'd5;
        load_start = 1'b1;
        load_abort = 1'b1;
        tick();
        load_start = 1'b0;
        load_abort = 1'b0;
        check("abort_start_busy", load_busy, 0);
        check("abort_start_tvalid", table_valid, 1);

        // Zero length.
        run_load(8'd30, 9'd0, 8'h00, 1'b0, -1, lat, rs);
        check("len0_lat", lat, 1);
        check("len0_no_ready", rs, 0);
        check("len0_tvalid", table_valid, 1);
        read_chk("len0_no_write", 8'd30, 8'd30 ^ 8'hA5);

        // Oversized length saturates to the table depth.
        run_load(8'd0, 9'd300, 8'h0F, 1'b0, -1, lat, rs);
        check("len300_lat", lat, 257);
        check("len300_tvalid", table_valid, 1);
        check("len300_idle", load_busy, 0);
        read_chk("len300_a0", 8'd0, 8'h00 ^ 8'h0F);
        read_chk("len300_a128", 8'd128, 8'd128 ^ 8'h0F);
        read_chk("len300_a255", 8'd255, 8'd255 ^ 8'h0F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
